// File: rtl/burst_write_master.sv
// burst_write_master: Avalon-MM bursting write master fed by a local
// show-ahead write FIFO. A burst is posted only once every beat of it is
// already buffered, so master_write never stalls for lack of data.
// Optional feature macro: BURST_WRITE_MASTER_FIXED_LOCATION_EN
//   defined   -> control_fixed_location is captured and holds the address
//   undefined -> the address always increments; the port is ignored
module burst_write_master #(
   parameter int DATAWIDTH       = 32,
   parameter int MAXBURSTCOUNT   = 8,
   parameter int BURSTCOUNTWIDTH = 4,
   parameter int BYTEENABLEWIDTH = 4,
   parameter int ADDRESSWIDTH    = 32,
   parameter int FIFODEPTH       = 32,
   parameter int FIFODEPTH_LOG2  = 5
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       control_fixed_location,
   input  logic [ADDRESSWIDTH-1:0]    control_write_base,
   input  logic [ADDRESSWIDTH-1:0]    control_write_length,
   input  logic                       control_go,
   output logic                       control_done,
   input  logic                       user_write_buffer,
   input  logic [DATAWIDTH-1:0]       user_buffer_data,
   output logic                       user_buffer_full,
   output logic [ADDRESSWIDTH-1:0]    master_address,
   output logic                       master_write,
   output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
   output logic [DATAWIDTH-1:0]       master_writedata,
   output logic [BURSTCOUNTWIDTH-1:0] master_burstcount,
   input  logic                       master_waitrequest
);

   localparam int BE_LOG2 = $clog2(BYTEENABLEWIDTH);
   localparam logic [ADDRESSWIDTH-1:0]    MAX_BEATS = ADDRESSWIDTH'(MAXBURSTCOUNT);
   localparam logic [ADDRESSWIDTH-1:0]    BEAT_MASK = ADDRESSWIDTH'(MAXBURSTCOUNT - 1);
   localparam logic [ADDRESSWIDTH-1:0]    LOW_MASK  = ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
   localparam logic [BURSTCOUNTWIDTH-1:0] ONE_BEAT  = BURSTCOUNTWIDTH'(1);
   localparam logic [FIFODEPTH_LOG2-1:0]  PTR_ONE   = FIFODEPTH_LOG2'(1);
   localparam logic [FIFODEPTH_LOG2:0]    USED_ONE  = (FIFODEPTH_LOG2 + 1)'(1);
   localparam logic [FIFODEPTH_LOG2:0]    USED_FULL = (FIFODEPTH_LOG2 + 1)'(FIFODEPTH);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t state, state_next;

   logic [ADDRESSWIDTH-1:0]    address;
   logic [ADDRESSWIDTH-1:0]    length;
   logic                       fixed_d1;
   logic                       fixed_sel;
   logic [BURSTCOUNTWIDTH-1:0] burstcount;
   logic [BURSTCOUNTWIDTH-1:0] beats_left;

   logic [DATAWIDTH-1:0]       fifo_mem [FIFODEPTH];
   logic [FIFODEPTH_LOG2-1:0]  rd_ptr;
   logic [FIFODEPTH_LOG2-1:0]  wr_ptr;
   logic [FIFODEPTH_LOG2:0]    fifo_used;

   logic                       start;
   logic                       push;
   logic                       pop;
   logic                       accept;
   logic                       last_beat;
   logic                       load_burst;

   logic [ADDRESSWIDTH-1:0]    words;
   logic [ADDRESSWIDTH-1:0]    burst_word;
   logic [ADDRESSWIDTH-1:0]    room;
   logic [ADDRESSWIDTH-1:0]    count_wide;
   logic [BURSTCOUNTWIDTH-1:0] count_next;
   logic [ADDRESSWIDTH-1:0]    burst_bytes;

`ifdef BURST_WRITE_MASTER_FIXED_LOCATION_EN
   assign fixed_sel = control_fixed_location;
`else
   logic unused_fixed_location;
   assign unused_fixed_location = control_fixed_location;
   assign fixed_sel             = 1'b0;
`endif

   assign control_done      = (length == '0) && (state == IDLE);
   assign start             = control_go && control_done;
   assign accept            = (state == BURST) && !master_waitrequest;
   assign last_beat         = accept && (beats_left == ONE_BEAT);
   assign pop               = accept;
   assign push              = user_write_buffer && !user_buffer_full;
   assign user_buffer_full  = (fifo_used == USED_FULL);
   assign burst_bytes       = ADDRESSWIDTH'(burstcount) << BE_LOG2;

   assign master_address    = address;
   assign master_burstcount = burstcount;
   assign master_byteenable = '1;
   assign master_writedata  = fifo_mem[rd_ptr];

   // Burst size: run up to the next MAXBURSTCOUNT-word boundary, capped by the words left
   always_comb begin
      words      = length >> BE_LOG2;
      burst_word = (address >> BE_LOG2) & BEAT_MASK;
      room       = MAX_BEATS - burst_word;
      count_wide = MAX_BEATS;
      if (burst_word != '0) begin
         count_wide = (room < words) ? room : words;
      end else if (words < MAX_BEATS) begin
         count_wide = words;
      end
      count_next = BURSTCOUNTWIDTH'(count_wide);
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: launch only when the whole burst is already buffered
   always_comb begin
      state_next   = state;
      master_write = 1'b0;
      load_burst   = 1'b0;
      case (state)
         IDLE: begin
            if ((length != '0) && (ADDRESSWIDTH'(fifo_used) >= count_wide)) begin
               load_burst = 1'b1;
               state_next = BURST;
            end
         end
         BURST: begin
            master_write = 1'b1;
            if (last_beat) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Transfer registers: load on go, advance once per completed burst
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         address    <= '0;
         length     <= '0;
         fixed_d1   <= 1'b0;
         burstcount <= '0;
         beats_left <= '0;
      end else begin
         if (start) begin
            address  <= control_write_base;
            length   <= control_write_length & ~LOW_MASK;
            fixed_d1 <= fixed_sel;
         end else if (last_beat) begin
            length <= length - burst_bytes;
            if (!fixed_d1) begin
               address <= address + burst_bytes;
            end
         end
         if (load_burst) begin
            burstcount <= count_next;
            beats_left <= count_next;
         end else if (accept) begin
            beats_left <= beats_left - ONE_BEAT;
         end
      end
   end

   // FIFO storage; contents are discarded on reset through the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= user_buffer_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         fifo_used <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   fifo_used <= fifo_used + USED_ONE;
            2'b01:   fifo_used <= fifo_used - USED_ONE;
            default: fifo_used <= fifo_used;
         endcase
      end
   end

endmodule

// File: tb/tb_burst_write_master.sv
// tb_burst_write_master: directed bench for burst_write_master.
// A negedge monitor logs every write-request cycle and every accepted beat;
// the directed sequences compare those logs against hand-computed values.
module tb_burst_write_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        control_fixed_location = 1'b0;
   logic [31:0] control_write_base = '0;
   logic [31:0] control_write_length = '0;
   logic        control_go = 1'b0;
   logic        control_done;
   logic        user_write_buffer = 1'b0;
   logic [31:0] user_buffer_data = '0;
   logic        user_buffer_full;
   logic [31:0] master_address;
   logic        master_write;
   logic [3:0]  master_byteenable;
   logic [31:0] master_writedata;
   logic [3:0]  master_burstcount;
   logic        master_waitrequest = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pushes = 0;
   logic prev_write = 1'b0;

   logic [31:0] wq_addr[$];
   logic [31:0] wq_bc[$];
   logic [31:0] bq_data[$];
   logic [31:0] bq_addr[$];
   int          starts[$];
   int          push_at_start[$];

   burst_write_master #(
      .DATAWIDTH(32),
      .MAXBURSTCOUNT(8),
      .BURSTCOUNTWIDTH(4),
      .BYTEENABLEWIDTH(4),
      .ADDRESSWIDTH(32),
      .FIFODEPTH(32),
      .FIFODEPTH_LOG2(5)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .control_fixed_location(control_fixed_location),
      .control_write_base(control_write_base),
      .control_write_length(control_write_length),
      .control_go(control_go),
      .control_done(control_done),
      .user_write_buffer(user_write_buffer),
      .user_buffer_data(user_buffer_data),
      .user_buffer_full(user_buffer_full),
      .master_address(master_address),
      .master_write(master_write),
      .master_byteenable(master_byteenable),
      .master_writedata(master_writedata),
      .master_burstcount(master_burstcount),
      .master_waitrequest(master_waitrequest)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Bus monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (reset_n && master_write) begin
         wq_addr.push_back(master_address);
         wq_bc.push_back({28'd0, master_burstcount});
         if (!prev_write) begin
            starts.push_back(cyc);
            push_at_start.push_back(pushes);
         end
         if (!master_waitrequest) begin
            bq_data.push_back(master_writedata);
            bq_addr.push_back(master_address);
         end
      end
      prev_write = reset_n && master_write;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      wq_addr.delete();
      wq_bc.delete();
      bq_data.delete();
      bq_addr.delete();
      starts.delete();
      push_at_start.delete();
      pushes = 0;
   endtask

   task automatic push(input logic [31:0] d);
      user_write_buffer = 1'b1;
      user_buffer_data  = d;
      tick();
      user_write_buffer = 1'b0;
      pushes++;
   endtask

   task automatic go(input logic [31:0] base, input logic [31:0] len, input logic fixed);
      control_write_base     = base;
      control_write_length   = len;
      control_fixed_location = fixed;
      control_go             = 1'b1;
      tick();
      control_go             = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!control_done && n < budget) begin
         tick();
         n++;
      end
      check(tag, {31'd0, control_done}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_a2;

      // Reset values
      #3;
      check("rst_write", {31'd0, master_write}, 32'd0);
      check("rst_addr", master_address, 32'd0);
      check("rst_bc", {28'd0, master_burstcount}, 32'd0);
      check("rst_done", {31'd0, control_done}, 32'd1);
      check("rst_full", {31'd0, user_buffer_full}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      check("byteenable", {28'd0, master_byteenable}, 32'hF);

      // 1: aligned 64-byte transfer, data preloaded
      clear_mon();
      for (int i = 0; i < 16; i++) push(32'hA000 + i);
      go(32'h100, 32'd64, 1'b0);
      check("t1_done_low", {31'd0, control_done}, 32'd0);
      check("t1_write_c1", {31'd0, master_write}, 32'd0);
      tick();
      check("t1_write_c2", {31'd0, master_write}, 32'd1);
      check("t1_addr0", master_address, 32'h100);
      check("t1_bc0", {28'd0, master_burstcount}, 32'd8);
      wait_done("t1_done", 100);
      check("t1_beats", bq_data.size(), 32'd16);
      check("t1_wcycles", wq_addr.size(), 32'd16);
      check("t1_bursts", starts.size(), 32'd2);
      if (starts.size() == 2) check("t1_gap", starts[1] - starts[0], 32'd9);
      for (int i = 0; i < bq_data.size(); i++) begin
         check("t1_data", bq_data[i], 32'hA000 + i);
         check("t1_baddr", bq_addr[i], (i < 8) ? 32'h100 : 32'h120);
      end

      // 2: unaligned base splits into 6 + 2
      clear_mon();
      for (int i = 0; i < 8; i++) push(32'hB000 + i);
      go(32'h108, 32'd32, 1'b0);
      wait_done("t2_done", 100);
      check("t2_beats", bq_data.size(), 32'd8);
      check("t2_bursts", starts.size(), 32'd2);
      if (wq_addr.size() == 8) begin
         check("t2_addr0", wq_addr[0], 32'h108);
         check("t2_bc0", wq_bc[0], 32'd6);
         check("t2_addr1", wq_addr[6], 32'h120);
         check("t2_bc1", wq_bc[6], 32'd2);
      end
      for (int i = 0; i < bq_data.size(); i++) check("t2_data", bq_data[i], 32'hB000 + i);

      // 3: slow producer, bursts wait for full data and run without gaps
      clear_mon();
      go(32'h200, 32'd64, 1'b0);
      for (int i = 0; i < 16; i++) begin
         push(32'hC000 + i);
         tick();
         tick();
      end
      wait_done("t3_done", 100);
      check("t3_bursts", starts.size(), 32'd2);
      if (push_at_start.size() == 2) begin
         check("t3_avail0", {31'd0, push_at_start[0] >= 8}, 32'd1);
         check("t3_avail1", {31'd0, push_at_start[1] >= 16}, 32'd1);
      end
      check("t3_wcycles", wq_addr.size(), 32'd16);
      check("t3_beats", bq_data.size(), 32'd16);
      for (int i = 0; i < bq_data.size(); i++) begin
         check("t3_data", bq_data[i], 32'hC000 + i);
         check("t3_baddr", bq_addr[i], (i < 8) ? 32'h200 : 32'h220);
      end

      // 4: alternate waitrequest, beats held until accepted
      clear_mon();
      for (int i = 0; i < 8; i++) push(32'hD000 + i);
      go(32'h300, 32'd32, 1'b0);
      for (int n = 0; n < 100 && !control_done; n++) begin
         master_waitrequest = ~master_waitrequest;
         tick();
      end
      master_waitrequest = 1'b0;
      check("t4_done", {31'd0, control_done}, 32'd1);
      check("t4_beats", bq_data.size(), 32'd8);
      check("t4_stalled", {31'd0, wq_addr.size() > 8}, 32'd1);
      for (int i = 0; i < wq_addr.size(); i++) begin
         check("t4_addr", wq_addr[i], 32'h300);
         check("t4_bc", wq_bc[i], 32'd8);
      end
      for (int i = 0; i < bq_data.size(); i++) check("t4_data", bq_data[i], 32'hD000 + i);

      // 5: overfill; 33rd push is dropped
      clear_mon();
      for (int i = 0; i < 32; i++) begin
         if (i == 31) check("t5_notfull", {31'd0, user_buffer_full}, 32'd0);
         push(32'hE000 + i);
      end
      check("t5_full", {31'd0, user_buffer_full}, 32'd1);
      push(32'hE020);
      check("t5_still_full", {31'd0, user_buffer_full}, 32'd1);
      go(32'h400, 32'd128, 1'b0);
      wait_done("t5_done", 200);
      check("t5_beats", bq_data.size(), 32'd32);
      check("t5_empty", {31'd0, user_buffer_full}, 32'd0);
      for (int i = 0; i < bq_data.size(); i++) begin
         check("t5_data", bq_data[i], 32'hE000 + i);
         check("t5_baddr", bq_addr[i], 32'h400 + 32 * (i / 8));
      end
      clear_mon();
      go(32'h500, 32'd4, 1'b0);
      repeat (6) tick();
      check("t5_nowrite", wq_addr.size(), 32'd0);
      push(32'h5A5A);
      wait_done("t5b_done", 20);
      check("t5b_beats", bq_data.size(), 32'd1);
      if (bq_data.size() == 1) begin
         check("t5b_data", bq_data[0], 32'h5A5A);
         check("t5b_addr", bq_addr[0], 32'h500);
         check("t5b_bc", wq_bc[0], 32'd1);
      end

      // 6: reset in the middle of a burst
      clear_mon();
      for (int i = 0; i < 8; i++) push(32'hF000 + i);
      go(32'h600, 32'd32, 1'b0);
      for (int n = 0; n < 50 && bq_data.size() < 3; n++) tick();
      check("t6_reached", bq_data.size(), 32'd3);
      reset_n = 1'b0;
      #1;
      check("t6_write", {31'd0, master_write}, 32'd0);
      check("t6_done", {31'd0, control_done}, 32'd1);
      check("t6_full", {31'd0, user_buffer_full}, 32'd0);
      check("t6_bc", {28'd0, master_burstcount}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      clear_mon();
      go(32'h700, 32'd4, 1'b0);
      repeat (6) tick();
      check("t6_fifo_empty", wq_addr.size(), 32'd0);
      push(32'h1234);
      wait_done("t6b_done", 20);
      check("t6b_beats", bq_data.size(), 32'd1);
      if (bq_data.size() == 1) check("t6b_data", bq_data[0], 32'h1234);

      // Fixed-location request: honoured only when the feature is built in
      clear_mon();
      for (int i = 0; i < 16; i++) push(32'h9000 + i);
      go(32'h800, 32'd64, 1'b1);
      control_fixed_location = 1'b0;
      wait_done("t7_done", 100);
`ifdef BURST_WRITE_MASTER_FIXED_LOCATION_EN
      exp_a2 = 32'h800;
`else
      exp_a2 = 32'h820;
`endif
      check("t7_beats", bq_data.size(), 32'd16);
      check("t7_bursts", starts.size(), 32'd2);
      for (int i = 0; i < bq_data.size(); i++) begin
         check("t7_data", bq_data[i], 32'h9000 + i);
         check("t7_baddr", bq_addr[i], (i < 8) ? 32'h800 : exp_a2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
